// File: rtl/stream_mux_rr.sv
// Registered N:1 stream multiplexer with valid/ready handshakes on every channel.
// Arbitration is round-robin or fixed priority (lowest index wins). The output register isolates the consumer.
module stream_mux_rr #(
   parameter int N_CH    = 4,
   parameter int W       = 4,
   parameter int RR_MODE = 1,
   localparam int SEL_W  = $clog2(N_CH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_CH-1:0]      in_valid,
   input  logic [N_CH*W-1:0]    in_data,
   output logic [N_CH-1:0]      in_ready,
   output logic                 out_valid,
   output logic [W-1:0]         out_data,
   output logic [SEL_W-1:0]     out_sel,
   input  logic                 out_ready
);

   localparam logic [SEL_W:0]   N_EXT = (SEL_W+1)'(N_CH);
   localparam logic [SEL_W-1:0] LAST  = SEL_W'(N_CH-1);

   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] base;
   logic [SEL_W-1:0] gnt_idx;
   logic [SEL_W-1:0] ptr_nxt;
   logic [SEL_W:0]   scan;
   logic [N_CH-1:0]  grant;
   logic [W-1:0]     sel_data;
   logic             any_grant;
   logic             load;

   assign load = !out_valid || out_ready;
   assign base = (RR_MODE != 0) ? ptr : '0;

   // Scan starts at base and wraps modulo N_CH, so an index >= N_CH is never formed.
   always_comb begin
      grant     = '0;
      gnt_idx   = '0;
      any_grant = 1'b0;
      scan      = '0;
      for (int k = 0; k < N_CH; k++) begin
         scan = {1'b0, base} + (SEL_W+1)'(k);
         if (scan >= N_EXT) begin
            scan = scan - N_EXT;
         end
         if (!any_grant && in_valid[scan[SEL_W-1:0]]) begin
            any_grant = 1'b1;
            gnt_idx   = scan[SEL_W-1:0];
         end
      end
      if (any_grant) begin
         grant[gnt_idx] = 1'b1;
      end
   end

   always_comb begin
      sel_data = in_data[gnt_idx*W +: W];
      ptr_nxt  = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
      in_ready = (rst_n && load) ? grant : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr       <= '0;
      end else if (load) begin
         if (any_grant) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_sel   <= gnt_idx;
            if (RR_MODE != 0) begin
               ptr <= ptr_nxt;
            end
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Testbench for stream_mux_rr: vector table, corner sequences, and random traffic against a queue-free reference model.
// Three instances cover round-robin N=4, fixed priority N=4, and round-robin N=3.
module tb_stream_mux_rr;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Round-robin, N_CH = 4
   logic        rst_n, out_ready, out_valid;
   logic [3:0]  in_valid, in_ready, out_data;
   logic [15:0] in_data;
   logic [1:0]  out_sel;

   // Fixed priority, N_CH = 4
   logic        f_rst_n, f_out_ready, f_out_valid;
   logic [3:0]  f_in_valid, f_in_ready, f_out_data;
   logic [15:0] f_in_data;
   logic [1:0]  f_out_sel;

   // Round-robin, N_CH = 3
   logic        n_rst_n, n_out_ready, n_out_valid;
   logic [2:0]  n_in_valid, n_in_ready;
   logic [11:0] n_in_data;
   logic [3:0]  n_out_data;
   logic [1:0]  n_out_sel;

   stream_mux_rr #(.N_CH(4), .W(4), .RR_MODE(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
      .out_sel(out_sel), .out_ready(out_ready));

   stream_mux_rr #(.N_CH(4), .W(4), .RR_MODE(0)) dut_fixed (
      .clk(clk), .rst_n(f_rst_n), .in_valid(f_in_valid), .in_data(f_in_data),
      .in_ready(f_in_ready), .out_valid(f_out_valid), .out_data(f_out_data),
      .out_sel(f_out_sel), .out_ready(f_out_ready));

   stream_mux_rr #(.N_CH(3), .W(4), .RR_MODE(1)) dut_n3 (
      .clk(clk), .rst_n(n_rst_n), .in_valid(n_in_valid), .in_data(n_in_data),
      .in_ready(n_in_ready), .out_valid(n_out_valid), .out_data(n_out_data),
      .out_sel(n_out_sel), .out_ready(n_out_ready));

   typedef struct {
      logic        rst;
      logic [3:0]  valid;
      logic [15:0] data;
      logic        ordy;
      logic [3:0]  exp_ready;
      logic        exp_valid;
      logic [3:0]  exp_data;
      logic [1:0]  exp_sel;
   } vec_t;

   vec_t tbl[17];

   // Reference model state for the round-robin N=4 instance
   int         m_ptr;
   logic       m_valid;
   logic [3:0] m_data;
   logic [1:0] m_sel;

   function automatic int pick(input logic [3:0] v, input int p);
      for (int k = 0; k < 4; k++) begin
         if (v[(p + k) % 4]) return (p + k) % 4;
      end
      return -1;
   endfunction

   task automatic applyStimulus(input logic r, input logic [3:0] v, input logic [15:0] d, input logic o);
      @(negedge clk);
      rst_n     = r;
      in_valid  = v;
      in_data   = d;
      out_ready = o;
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;   in_valid = '0;   in_data = '0;   out_ready = 1'b0;
      f_rst_n = 1'b0; f_in_valid = '0; f_in_data = '0; f_out_ready = 1'b0;
      n_rst_n = 1'b0; n_in_valid = '0; n_in_data = '0; n_out_ready = 1'b0;

      tbl[0]  = '{1'b0, 4'b1111, 16'hDCBA, 1'b1, 4'b0000, 1'b0, 4'h0, 2'd0};
      tbl[1]  = '{1'b1, 4'b0000, 16'hDCBA, 1'b1, 4'b0000, 1'b0, 4'h0, 2'd0};
      tbl[2]  = '{1'b1, 4'b1111, 16'hDCBA, 1'b1, 4'b0001, 1'b1, 4'hA, 2'd0};
      tbl[3]  = '{1'b1, 4'b1111, 16'hDCBA, 1'b1, 4'b0010, 1'b1, 4'hB, 2'd1};
      tbl[4]  = '{1'b1, 4'b1111, 16'hDCBA, 1'b1, 4'b0100, 1'b1, 4'hC, 2'd2};
      tbl[5]  = '{1'b1, 4'b1111, 16'hDCBA, 1'b1, 4'b1000, 1'b1, 4'hD, 2'd3};
      tbl[6]  = '{1'b1, 4'b1111, 16'hDCBA, 1'b1, 4'b0001, 1'b1, 4'hA, 2'd0};
      tbl[7]  = '{1'b1, 4'b0010, 16'h0090, 1'b1, 4'b0010, 1'b1, 4'h9, 2'd1};
      tbl[8]  = '{1'b1, 4'b1111, 16'hDCBA, 1'b0, 4'b0000, 1'b1, 4'h9, 2'd1};
      tbl[9]  = '{1'b1, 4'b1111, 16'hDCBA, 1'b0, 4'b0000, 1'b1, 4'h9, 2'd1};
      tbl[10] = '{1'b1, 4'b1111, 16'hDCBA, 1'b0, 4'b0000, 1'b1, 4'h9, 2'd1};
      tbl[11] = '{1'b1, 4'b1111, 16'hDCBA, 1'b1, 4'b0100, 1'b1, 4'hC, 2'd2};
      tbl[12] = '{1'b1, 4'b0000, 16'hDCBA, 1'b1, 4'b0000, 1'b0, 4'hC, 2'd2};
      tbl[13] = '{1'b1, 4'b0000, 16'hDCBA, 1'b0, 4'b0000, 1'b0, 4'hC, 2'd2};
      tbl[14] = '{1'b1, 4'b0001, 16'hDCBA, 1'b0, 4'b0001, 1'b1, 4'hA, 2'd0};
      tbl[15] = '{1'b0, 4'b1111, 16'hDCBA, 1'b0, 4'b0000, 1'b0, 4'h0, 2'd0};
      tbl[16] = '{1'b1, 4'b1111, 16'hDCBA, 1'b1, 4'b0001, 1'b1, 4'hA, 2'd0};

      for (int i = 0; i < 17; i++) begin
         applyStimulus(tbl[i].rst, tbl[i].valid, tbl[i].data, tbl[i].ordy);
         checkOutput($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].exp_ready));
         tick();
         checkOutput($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].exp_valid));
         checkOutput($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(tbl[i].exp_data));
         checkOutput($sformatf("tbl%0d_out_sel", i), 32'(out_sel), 32'(tbl[i].exp_sel));
      end

      // Single active channel streams back-to-back; pointer then sits just past it
      for (int b = 1; b <= 5; b++) begin
         applyStimulus(1'b1, 4'b0100, 16'(b) << 8, 1'b1);
         checkOutput("solo_in_ready", 32'(in_ready), 32'h4);
         tick();
         checkOutput("solo_out_valid", 32'(out_valid), 32'h1);
         checkOutput("solo_out_data", 32'(out_data), 32'(b));
         checkOutput("solo_out_sel", 32'(out_sel), 32'd2);
      end
      applyStimulus(1'b1, 4'b1111, 16'hDCBA, 1'b1);
      checkOutput("solo_after_ready", 32'(in_ready), 32'h8);
      tick();
      checkOutput("solo_after_sel", 32'(out_sel), 32'd3);

      // Fixed priority: ch1 always beats ch3
      @(negedge clk);
      f_rst_n = 1'b1; f_in_valid = 4'b1010; f_in_data = 16'hDCBA; f_out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         checkOutput("fixed_in_ready", 32'(f_in_ready), 32'h2);
         tick();
         checkOutput("fixed_out_sel", 32'(f_out_sel), 32'd1);
         checkOutput("fixed_out_data", 32'(f_out_data), 32'hB);
         @(negedge clk);
      end
      f_in_valid = 4'b1111;
      #1;
      checkOutput("fixed_all_ready", 32'(f_in_ready), 32'h1);
      tick();
      checkOutput("fixed_all_sel", 32'(f_out_sel), 32'd0);

      // N_CH = 3: rotation wraps 2 -> 0 and never names channel 3
      @(negedge clk);
      n_rst_n = 1'b1; n_in_valid = 3'b111; n_in_data = 12'hCBA; n_out_ready = 1'b1;
      for (int k = 0; k < 7; k++) begin
         tick();
         checkOutput("n3_out_sel", 32'(n_out_sel), 32'(k % 3));
         checkOutput("n3_out_data", 32'(n_out_data), 32'(4'hA + k % 3));
         checkOutput("n3_sel_range", 32'(n_out_sel < 2'd3), 32'h1);
         @(negedge clk);
      end
      n_out_ready = 1'b0;
      #1;
      checkOutput("n3_stall_ready", 32'(n_in_ready), 32'h0);
      tick();
      checkOutput("n3_stall_valid", 32'(n_out_valid), 32'h1);
      checkOutput("n3_stall_sel", 32'(n_out_sel), 32'd0);
      @(negedge clk);
      n_rst_n = 1'b0;
      #1;
      checkOutput("n3_rst_ready", 32'(n_in_ready), 32'h0);
      tick();
      checkOutput("n3_rst_valid", 32'(n_out_valid), 32'h0);

      // Random traffic against the reference model, starting from reset
      m_ptr = 0; m_valid = 1'b0; m_data = '0; m_sel = '0;
      for (int i = 0; i < 400; i++) begin
         logic       r, o, ld;
         logic [3:0] v, exp_rdy;
         logic [15:0] d;
         int g;
         r = (i == 0) ? 1'b0 : ($urandom_range(0, 49) != 0);
         v = 4'($urandom);
         d = 16'($urandom);
         o = ($urandom_range(0, 3) != 0);
         applyStimulus(r, v, d, o);
         g  = pick(v, m_ptr);
         ld = !m_valid || o;
         exp_rdy = (r && ld && g >= 0) ? 4'(1 << g) : 4'h0;
         checkOutput("rand_in_ready", 32'(in_ready), 32'(exp_rdy));
         tick();
         if (!r) begin
            m_valid = 1'b0; m_data = '0; m_sel = '0; m_ptr = 0;
         end else if (ld) begin
            if (g >= 0) begin
               m_valid = 1'b1;
               m_data  = d[g*4 +: 4];
               m_sel   = 2'(g);
               m_ptr   = (g + 1) % 4;
            end else begin
               m_valid = 1'b0;
            end
         end
         checkOutput("rand_out_valid", 32'(out_valid), 32'(m_valid));
         checkOutput("rand_out_data", 32'(out_data), 32'(m_data));
         checkOutput("rand_out_sel", 32'(out_sel), 32'(m_sel));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
